fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 16 +
 rtl/fifo_rd_stream_skid.sv | 63 ++++++
 rtl/fifo_rd_stream.sv | 103 ++++++++++
 tb/tb_fifo_rd_stream.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side drain path.
//   FIFO_DATA_W : word width shared with the synchronous FIFO
//   SKID_DEPTH  : entries in the read-latency skid buffer
//   rd_state_e  : drain controller states
package fifo_rd_stream_pkg;

  localparam int unsigned FIFO_DATA_W = 8;
  localparam int unsigned SKID_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_skid.sv
// Two-entry valid/ready skid buffer absorbing the FIFO read latency.
//   clk, rstn          : clock, asynchronous active-low reset
//   i_push, i_data     : word arriving from the FIFO read port
//   i_pop              : downstream consumed the head word
//   o_valid, o_data    : head word
//   o_occ              : number of buffered words (0..2)
module fifo_rd_stream_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_occ
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic [1:0]        occ;
  logic              pop_eff;

  assign pop_eff = i_pop && (occ != 2'd0);

  // head always holds the oldest word; tail is only used when two are held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      case ({i_push, pop_eff})
        2'b10: begin
          if (occ == 2'd0) head <= i_data;
          else             tail <= i_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= i_data;
          end else begin
            head <= tail;
            tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid = (occ != 2'd0);
  assign o_data  = head;
  assign o_occ   = occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller for the synchronous FIFO.
// Issues FIFO reads on watermark or flush request, buffers the 1-cycle read
// latency in a 2-entry skid buffer and presents words on a valid/ready stream.
//   clk, rstn                  : clock, asynchronous active-low reset
//   o_rden, i_rddata           : FIFO read enable / data (data 1 cycle later)
//   i_empty, i_alm_empty       : FIFO status flags
//   i_flush                    : single-cycle flush request
//   o_valid, o_data, i_ready   : output stream
//   o_flush_done               : one-cycle pulse when a flush has completed
//   o_rd_count                 : delivered-word counter (wraps)
//   o_busy                     : not idle, or words in flight / buffered
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              o_rden,
  input  logic [DATA_W-1:0] i_rddata,
  input  logic              i_empty,
  input  logic              i_alm_empty,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_flush_done,
  output logic [CNT_W-1:0]  o_rd_count,
  output logic              o_busy
);

  rd_state_e        state, state_nxt;
  logic             inflight;
  logic [1:0]       occ;
  logic             pop;
  logic             done_nxt;
  logic [2:0]       credit_sum;
  logic [CNT_W-1:0] rd_cnt;
  logic             flush_done_q;

  assign pop = o_valid && i_ready;

  // Words committed after this cycle's pop; a new read may only be issued
  // while that stays below the skid depth, so the buffer never overflows.
  assign credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign o_rden     = (state != IDLE) && !i_empty && (credit_sum < 3'(SKID_DEPTH));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_flush)           state_nxt = FLUSH;
        else if (!i_alm_empty) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (i_flush)                    state_nxt = FLUSH;
        else if (i_empty && !inflight)  state_nxt = IDLE;
      end
      FLUSH: begin
        if (i_empty && !inflight && (occ == 2'd0)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      inflight     <= 1'b0;
      flush_done_q <= 1'b0;
      rd_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      inflight     <= o_rden;
      flush_done_q <= done_nxt;
      if (pop) rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end

  // Read data is valid exactly one cycle after o_rden, i.e. while inflight.
  fifo_rd_stream_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (inflight),
    .i_data  (i_rddata),
    .i_pop   (pop),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_occ   (occ)
  );

  assign o_flush_done = flush_done_q;
  assign o_rd_count   = rd_cnt;
  assign o_busy       = (state != IDLE) || inflight || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, transaction-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_fifo_rd_stream;
  import fifo_rd_stream_pkg::*;

  localparam int ALM_THR = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        o_rden;
  logic [7:0]  rddata;
  logic        fifo_empty;
  logic        fifo_alm;
  logic        i_flush;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        i_ready;
  logic        o_flush_done;
  logic [15:0] o_rd_count;
  logic        o_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_W (8),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .o_rden       (o_rden),
    .i_rddata     (rddata),
    .i_empty      (fifo_empty),
    .i_alm_empty  (fifo_alm),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_flush_done (o_flush_done),
    .o_rd_count   (o_rd_count),
    .o_busy       (o_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural synchronous FIFO ----------------
  logic [7:0] fq[$];
  int         fcount;
  int         load_n = 0;
  logic       load_go = 1'b0;

  assign fifo_empty = (fcount == 0);
  assign fifo_alm   = (fcount <= ALM_THR);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      fcount <= 0;
      rddata <= '0;
    end else begin
      if (o_rden && fq.size() != 0) rddata <= fq.pop_front();
      if (load_go) for (int i = 0; i < load_n; i++) fq.push_back(8'(i + 1));
      fcount <= fq.size();
    end
  end

  // ---------------- reference model ----------------
  rd_state_e  mstate = IDLE;
  rd_state_e  mnext;
  logic       mdone = 1'b0;
  logic [15:0] mcnt = '0;
  int         cyc = 0;
  int         iss_q[$];
  logic [7:0] wq[$];
  logic [7:0] mq[$];
  int         outst, occm;
  logic       infl, ev, mpop, er, mempty, nd;

  always begin
    @(negedge clk);
    #1;
    if (!rstn) begin
      mstate = IDLE; mdone = 1'b0; mcnt = '0;
      iss_q.delete(); wq.delete(); mq.delete();
      chk("rst_rden",  32'(o_rden), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_data",  32'(o_data), 0);
      chk("rst_done",  32'(o_flush_done), 0);
      chk("rst_count", 32'(o_rd_count), 0);
      chk("rst_busy",  32'(o_busy), 0);
    end else begin
      mempty = (mq.size() == 0);
      outst  = iss_q.size();
      infl   = (outst > 0) && (iss_q[outst-1] == cyc - 1);
      occm   = outst - (infl ? 1 : 0);
      ev     = (outst > 0) && (iss_q[0] <= cyc - 2);
      mpop   = ev && i_ready;
      er     = (mstate != IDLE) && !mempty && ((outst - (mpop ? 1 : 0)) < 2);

      chk("m_empty", 32'(fifo_empty), 32'(mempty));
      chk("m_rden",  32'(o_rden), 32'(er));
      chk("m_valid", 32'(o_valid), 32'(ev));
      if (ev) chk("m_data", 32'(o_data), 32'(wq[0]));
      chk("m_busy",  32'(o_busy), 32'((mstate != IDLE) || (outst > 0)));
      chk("m_done",  32'(o_flush_done), 32'(mdone));
      chk("m_count", 32'(o_rd_count), 32'(mcnt));

      nd    = (mstate == FLUSH) && mempty && !infl && (occm == 0);
      mnext = mstate;
      case (mstate)
        IDLE:    if (i_flush) mnext = FLUSH; else if (mq.size() > ALM_THR) mnext = DRAIN;
        DRAIN:   if (i_flush) mnext = FLUSH; else if (mempty && !infl) mnext = IDLE;
        default: if (nd) mnext = IDLE;
      endcase
      if (mpop) begin
        void'(iss_q.pop_front());
        void'(wq.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (er) begin
        iss_q.push_back(cyc);
        wq.push_back(mq.pop_front());
      end
      if (load_go) for (int i = 0; i < load_n; i++) mq.push_back(8'(i + 1));
      mdone  = nd;
      mstate = mnext;
    end
    cyc++;
  end

  // ---------------- directed scenarios ----------------
  int         first_rd, n, nrd, done_cnt, dk, maxout, rds, pops;
  logic       busy_at_done;
  logic [7:0] got[64];
  int         gcyc[64];

  // Called at a negedge; returns at the negedge after the load edge.
  task automatic load(input int cnt);
    load_n  = cnt;
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  // rmode: 0 ready high, 1 toggle starting high, 2 ready low.
  task automatic collect(input int ncyc, input int rmode, input int fa, input int fb);
    first_rd = -1; n = 0; nrd = 0; done_cnt = 0; dk = -1;
    busy_at_done = 1'b1; maxout = 0; rds = 0; pops = 0;
    for (int k = 0; k < ncyc; k++) begin
      i_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((k % 2) == 0) : 1'b0;
      i_flush = (k == fa) || (k == fb);
      #2;
      if ((rds - pops) > maxout) maxout = rds - pops;
      if (o_rden) begin
        if (first_rd < 0) first_rd = k;
        nrd++;
        rds++;
      end
      if (o_valid && i_ready) begin
        if (n < 64) begin
          got[n]  = o_data;
          gcyc[n] = k;
        end
        n++;
        pops++;
      end
      if (o_flush_done) begin
        done_cnt++;
        dk = k;
        busy_at_done = o_busy;
      end
      @(negedge clk);
    end
    i_flush = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      #2;
      if (!o_busy && fifo_empty) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    chk(nm, 32'(ok), 1);
  endtask

  logic [15:0] wexp[2];
  int          np;

  initial begin
    i_flush = 1'b0;
    i_ready = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 1: watermark drain at full rate
    load(8);
    collect(30, 0, -1, -1);
    chk("t1_first_rd", 32'(first_rd), 1);
    chk("t1_latency", 32'(gcyc[0] - first_rd), 2);
    chk("t1_words", 32'(n), 8);
    for (int i = 0; i < 8; i++) chk("t1_data", 32'(got[i]), 32'(i + 1));
    chk("t1_back_to_back", 32'(gcyc[7] - gcyc[0]), 7);
    chk("t1_count", 32'(o_rd_count), 8);
    chk("t1_idle", 32'(o_busy), 0);

    // 2: ready toggling every cycle
    load(8);
    collect(40, 1, -1, -1);
    chk("t2_words", 32'(n), 8);
    for (int i = 0; i < 8; i++) chk("t2_data", 32'(got[i]), 32'(i + 1));
    chk("t2_max_outstanding", 32'(maxout), 2);
    chk("t2_count", 32'(o_rd_count), 16);

    // 3: single word below watermark, flushed (second flush pulse ignored)
    load(1);
    collect(4, 0, -1, -1);
    chk("t3_no_rd_below_wm", 32'(nrd), 0);
    collect(12, 0, 0, 2);
    chk("t3_first_rd", 32'(first_rd), 1);
    chk("t3_words", 32'(n), 1);
    chk("t3_data", 32'(got[0]), 32'h01);
    chk("t3_done_cnt", 32'(done_cnt), 1);
    chk("t3_done_cycle", 32'(dk), 5);
    chk("t3_busy_at_done", 32'(busy_at_done), 0);
    chk("t3_count", 32'(o_rd_count), 17);

    // 4: flush with everything empty
    collect(8, 0, 0, -1);
    chk("t4_no_rd", 32'(nrd), 0);
    chk("t4_done_cnt", 32'(done_cnt), 1);
    chk("t4_done_cycle", 32'(dk), 2);

    // 5: counter wrap
    load(65518);
    wait_idle(70000, "t5_bulk_timeout");
    chk("t5_count_ffff", 32'(o_rd_count), 32'hFFFF);
    wexp[0] = 16'h0000;
    wexp[1] = 16'h0001;
    load(2);
    np = 0;
    i_flush = 1'b1;
    for (int k = 0; k < 20 && np < 2; k++) begin
      #2;
      if (o_valid && i_ready) begin
        @(posedge clk);
        #1;
        chk("t5_wrap", 32'(o_rd_count), 32'(wexp[np]));
        np++;
      end
      @(negedge clk);
      i_flush = 1'b0;
    end
    i_flush = 1'b0;
    chk("t5_wrap_words", 32'(np), 2);
    wait_idle(20, "t5_idle_timeout");

    // 6: asynchronous reset with two words buffered
    i_ready = 1'b0;
    load(8);
    repeat (6) @(negedge clk);
    chk("t6_pre_valid", 32'(o_valid), 1);
    #3 rstn = 1'b0;
    #1;
    chk("t6_rst_rden",  32'(o_rden), 0);
    chk("t6_rst_valid", 32'(o_valid), 0);
    chk("t6_rst_data",  32'(o_data), 0);
    chk("t6_rst_done",  32'(o_flush_done), 0);
    chk("t6_rst_count", 32'(o_rd_count), 0);
    chk("t6_rst_busy",  32'(o_busy), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    collect(6, 0, -1, -1);
    chk("t6_no_valid_after_rst", 32'(n), 0);
    chk("t6_no_rd_after_rst", 32'(nrd), 0);
    load(3);
    collect(20, 0, -1, -1);
    chk("t6_words", 32'(n), 3);
    for (int i = 0; i < 3; i++) chk("t6_data", 32'(got[i]), 32'(i + 1));
    chk("t6_count", 32'(o_rd_count), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
